extractor_tabla_verdad: RTL and testbench
=========================================

Name: extractor_tabla_verdad

Overview:
- Sequential truth-table extractor; the reading end of a combinational sum-of-products block.
- Drives every input combination onto the function under test through Estimulo.
- Samples the function's 1-bit output and builds the full truth table.
- Streams the index of every minterm (output = 1) over a valid/ready handshake and counts them.
- Used on the lab board and in benches to characterise any ANCHO-input combinational function.

Parameters:
ANCHO, 4, input width of the function under test; table has 2^ANCHO entries
ESPERA, 1, settle cycles per combination before sampling Respuesta (legal range >= 1)

Ports:
Reloj  input  1  single clock, all state updates on rising edge
Reset_n  input  1  synchronous reset, active-low
Inicio  input  1  start request; sampled only in REPOSO
Estimulo  output  ANCHO  current combination, wired to the function's Entrada
Respuesta  input  1  function output (e.g. SumaProductos)
Tabla  output  2^ANCHO  Tabla[i] = Respuesta sampled for Estimulo = i
NumMinterms  output  ANCHO+1  number of 1s found so far
Minterm  output  ANCHO  index of the minterm being offered
MintermValido  output  1  Minterm valid
MintermListo  input  1  consumer ready
Ocupado  output  1  high in APLICA and EMITE
Fin  output  1  one-cycle completion pulse

Behaviour:
- Reset: Reset_n = 0 at an edge forces state REPOSO and clears every register. Estimulo, Tabla, NumMinterms, Minterm, MintermValido, Ocupado and Fin all read 0. Reset wins over every other event, including mid-sweep and mid-handshake. An in-progress minterm is dropped.
- States: REPOSO, APLICA, EMITE, FIN. All outputs are registered.
- REPOSO:
  - Inicio = 1 at an edge -> APLICA.
  - Same edge: Estimulo <= 0, settle counter <= 0, Tabla <= 0, NumMinterms <= 0.
  - Tabla and NumMinterms from the previous run hold until that edge.
- APLICA:
  - Counter increments each cycle.
  - At the edge where counter == ESPERA-1, Respuesta is sampled, so it has been stable for ESPERA full cycles of the current Estimulo.
  - Same edge: Tabla[Estimulo] <= Respuesta.
  - If Respuesta = 1: NumMinterms += 1, Minterm <= Estimulo, MintermValido <= 1, -> EMITE.
  - If Respuesta = 0: advance.
- EMITE:
  - Minterm and MintermValido held stable until an edge with MintermListo = 1.
  - At that edge: MintermValido <= 0, then advance.
  - Estimulo is frozen while in EMITE.
- Advance:
  - If Estimulo == 2^ANCHO-1 -> FIN; Estimulo keeps its final value.
  - Otherwise Estimulo += 1, counter <= 0, -> APLICA.
  - No wrap to 0 within a run.
- FIN: Fin = 1 for exactly one cycle, Ocupado = 0, then -> REPOSO.
- Inicio outside REPOSO is ignored; no queuing. Inicio held high restarts a new run one cycle after FIN.
- Cycle count: the run occupies 2^ANCHO*ESPERA + NumMinterms + (extra stall cycles while MintermListo = 0) cycles in APLICA/EMITE. Fin is high in the next cycle.
- Width: NumMinterms holds the full range 0..2^ANCHO without overflow.
- Respuesta is used only at sampling edges; glitches during settle are ignored.

Test Plan:
1. ANCHO = 4, ESPERA = 1, Respuesta = (E3&E2)|(E1&E0), MintermListo = 1, pulse Inicio.
   - Minterms 3, 7, 11, 12, 13, 14, 15 appear in order.
   - Tabla = 16'hF888, NumMinterms = 7.
   - Fin pulses in cycle 24 after the Inicio edge; Ocupado high for exactly 23 cycles.
2. Respuesta tied 0:
   - No MintermValido, Tabla = 0, NumMinterms = 0, Fin after 16 cycles.
   - Respuesta tied 1 instead: Tabla = 16'hFFFF, NumMinterms = 16 (5'b10000), 16 minterms 0..15.
3. Case 1 with MintermListo low for 5 cycles at minterm 7:
   - Minterm = 7 and MintermValido held unchanged; Estimulo stays 7.
   - Total run lengthens by exactly 5 cycles; final Tabla is unchanged.
4. ESPERA = 3, Respuesta = the case-1 function delayed 2 cycles:
   - Tabla = 16'hF888, proving the sample point is after 3 stable cycles.
   - ESPERA = 1 with the same delay yields a wrong table, which the bench flags.
5. Reset_n low for one edge while in EMITE at minterm 11:
   - Next cycle all outputs are 0 and the state is REPOSO.
   - A new Inicio performs a full clean run with Tabla = 16'hF888.
6. Inicio pulsed during APLICA:
   - Ignored; run completes normally.
   - Inicio held high continuously: back-to-back runs, each beginning one cycle after Fin, with Tabla cleared at each restart.

Source files
------------

// File: rtl/extractor_tabla_verdad.sv
// -----------------------------------------------------------------------------
// extractor_tabla_verdad
//
// Sequential truth-table extractor. It sweeps every input combination of an
// ANCHO-input combinational function and waits ESPERA settle cycles per
// combination. It then samples the function's 1-bit output, builds the full
// truth table and streams the index of every minterm over a valid/ready
// handshake while counting the minterms.
//
// Ports
//   Reloj          in   clock, all state changes on the rising edge
//   Reset_n        in   synchronous reset, active low
//   Inicio         in   start request, honoured only while idle
//   Estimulo       out  combination currently applied to the function
//   Respuesta      in   function output, sampled once per combination
//   Tabla          out  Tabla[i] = Respuesta sampled with Estimulo = i
//   NumMinterms    out  number of 1s found so far (0 .. 2^ANCHO)
//   Minterm        out  index of the minterm being offered
//   MintermValido  out  Minterm is valid
//   MintermListo   in   consumer accepts Minterm
//   Ocupado        out  high while sweeping or offering a minterm
//   Fin            out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module extractor_tabla_verdad #(
   parameter int ANCHO  = 4,
   parameter int ESPERA = 1
) (
   input  logic                    Reloj,
   input  logic                    Reset_n,
   input  logic                    Inicio,
   output logic [ANCHO-1:0]        Estimulo,
   input  logic                    Respuesta,
   output logic [(1<<ANCHO)-1:0]   Tabla,
   output logic [ANCHO:0]          NumMinterms,
   output logic [ANCHO-1:0]        Minterm,
   output logic                    MintermValido,
   input  logic                    MintermListo,
   output logic                    Ocupado,
   output logic                    Fin
);

   localparam int N  = 1 << ANCHO;
   localparam int CW = (ESPERA > 1) ? $clog2(ESPERA) : 1;
   localparam logic [CW-1:0]    CNT_ULT = CW'(ESPERA - 1);
   localparam logic [ANCHO-1:0] EST_ULT = '1;

   typedef enum logic [1:0] {
      REPOSO = 2'd0,
      APLICA = 2'd1,
      EMITE  = 2'd2,
      FIN    = 2'd3
   } estado_t;

   estado_t          state_q, state_d;
   logic [ANCHO-1:0] est_q,   est_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [N-1:0]     tabla_q, tabla_d;
   logic [ANCHO:0]   num_q,   num_d;
   logic [ANCHO-1:0] min_q,   min_d;
   logic             val_q,   val_d;
   logic             ocu_q,   ocu_d;
   logic             fin_q,   fin_d;
   logic             avanzar;

   // NOTE: non-blocking assignments so every register is updated from the
   // values it saw before the edge, independent of statement order.
   always_ff @(posedge Reloj) begin
      if (!Reset_n) begin
         state_q <= REPOSO;
         est_q   <= '0;
         cnt_q   <= '0;
         tabla_q <= '0;
         num_q   <= '0;
         min_q   <= '0;
         val_q   <= 1'b0;
         ocu_q   <= 1'b0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         est_q   <= est_d;
         cnt_q   <= cnt_d;
         tabla_q <= tabla_d;
         num_q   <= num_d;
         min_q   <= min_d;
         val_q   <= val_d;
         ocu_q   <= ocu_d;
         fin_q   <= fin_d;
      end
   end

   // NOTE: every signal gets its hold value first, so no path through the
   // case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d = state_q;
      est_d   = est_q;
      cnt_d   = cnt_q;
      tabla_d = tabla_q;
      num_d   = num_q;
      min_d   = min_q;
      val_d   = val_q;
      avanzar = 1'b0;

      case (state_q)
         REPOSO: begin
            // Previous table and count stay visible until the next start.
            if (Inicio) begin
               state_d = APLICA;
               est_d   = '0;
               cnt_d   = '0;
               tabla_d = '0;
               num_d   = '0;
            end
         end

         APLICA: begin
            cnt_d = cnt_q + 1'b1;
            // Sampling on the last settle cycle means Respuesta has seen the
            // current Estimulo for ESPERA full cycles.
            if (cnt_q == CNT_ULT) begin
               tabla_d[est_q] = Respuesta;
               if (Respuesta) begin
                  num_d   = num_q + 1'b1;
                  min_d   = est_q;
                  val_d   = 1'b1;
                  state_d = EMITE;
               end else begin
                  avanzar = 1'b1;
               end
            end
         end

         EMITE: begin
            // Estimulo stays frozen until the consumer takes the minterm.
            if (MintermListo) begin
               val_d   = 1'b0;
               avanzar = 1'b1;
            end
         end

         FIN: begin
            state_d = REPOSO;
         end

         default: begin
            state_d = REPOSO;
         end
      endcase

      // Shared advance step; the last combination ends the run without
      // wrapping Estimulo back to 0.
      if (avanzar) begin
         if (est_q == EST_ULT) begin
            state_d = FIN;
         end else begin
            est_d   = est_q + 1'b1;
            cnt_d   = '0;
            state_d = APLICA;
         end
      end
   end

   // Status outputs are decoded from the next state so they come straight
   // out of flops, aligned with the state they describe.
   always_comb begin
      ocu_d = (state_d == APLICA) || (state_d == EMITE);
      fin_d = (state_d == FIN);
   end

   assign Estimulo      = est_q;
   assign Tabla         = tabla_q;
   assign NumMinterms   = num_q;
   assign Minterm       = min_q;
   assign MintermValido = val_q;
   assign Ocupado       = ocu_q;
   assign Fin           = fin_q;

endmodule

// File: tb/tb_extractor_tabla_verdad.sv
// -----------------------------------------------------------------------------
// tb_extractor_tabla_verdad
//
// Bench for extractor_tabla_verdad. The main instance (ANCHO=4, ESPERA=1) is
// checked every cycle against a procedural model of a sweep. A second
// instance (ESPERA=3) is driven by a function delayed two cycles. Directed
// runs pin the model with hand-computed tables, minterm lists and run
// lengths.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_extractor_tabla_verdad;

   localparam int ANCHO = 4;
   localparam int N     = 16;

   logic Reloj = 1'b0;
   always #5 Reloj = ~Reloj;

   // main instance
   logic         Reset_n, Inicio, Respuesta, MintermListo;
   logic [3:0]   Estimulo, Minterm;
   logic [15:0]  Tabla;
   logic [4:0]   NumMinterms;
   logic         MintermValido, Ocupado, Fin;

   // ESPERA = 3 instance
   logic         Inicio3, Respuesta3, Listo3;
   logic [3:0]   Estimulo3, Minterm3;
   logic [15:0]  Tabla3;
   logic [4:0]   Num3;
   logic         Valido3, Ocupado3, Fin3;

   extractor_tabla_verdad #(.ANCHO(ANCHO), .ESPERA(1)) dut (
      .Reloj(Reloj), .Reset_n(Reset_n), .Inicio(Inicio), .Estimulo(Estimulo),
      .Respuesta(Respuesta), .Tabla(Tabla), .NumMinterms(NumMinterms),
      .Minterm(Minterm), .MintermValido(MintermValido),
      .MintermListo(MintermListo), .Ocupado(Ocupado), .Fin(Fin)
   );

   extractor_tabla_verdad #(.ANCHO(ANCHO), .ESPERA(3)) dut3 (
      .Reloj(Reloj), .Reset_n(Reset_n), .Inicio(Inicio3), .Estimulo(Estimulo3),
      .Respuesta(Respuesta3), .Tabla(Tabla3), .NumMinterms(Num3),
      .Minterm(Minterm3), .MintermValido(Valido3),
      .MintermListo(Listo3), .Ocupado(Ocupado3), .Fin(Fin3)
   );

   // function under test: (E3&E2)|(E1&E0)
   function automatic logic f_sop(input logic [3:0] e);
      return (e[3] & e[2]) | (e[1] & e[0]);
   endfunction

   // 0: f_sop, 1: tied 0, 2: tied 1, 3: f_sop delayed 2 cycles
   int   resp_mode;
   logic d1, d2, d1_3, d2_3;
   always @(posedge Reloj) begin
      d1   <= f_sop(Estimulo);
      d2   <= d1;
      d1_3 <= f_sop(Estimulo3);
      d2_3 <= d1_3;
   end
   assign Respuesta  = (resp_mode == 0) ? f_sop(Estimulo) :
                       (resp_mode == 1) ? 1'b0 :
                       (resp_mode == 2) ? 1'b1 : d2;
   assign Respuesta3 = d2_3;

   // bookkeeping
   int checks   = 0;
   int failures = 0;
   int cycle    = 0;
   int ocu_total = 0;
   int mq[$];
   int run_c0, run_oc0, run_q0;
   bit chk_en = 1'b0;

   always @(posedge Reloj) cycle <= cycle + 1;

   always @(negedge Reloj) begin
      if (Ocupado === 1'b1) ocu_total <= ocu_total + 1;
      if (MintermValido === 1'b1 && MintermListo === 1'b1) mq.push_back(int'(Minterm));
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: one sweep written as nested loops over combinations
   // and settle cycles. m_* hold what the outputs must be after each edge.
   // ---------------------------------------------------------------------------
   logic [3:0]  m_est, m_min;
   logic [15:0] m_tabla;
   logic [4:0]  m_num;
   logic        m_val, m_ocu, m_fin;
   bit          m_abort;

   task automatic m_clear();
      m_est = '0; m_min = '0; m_tabla = '0; m_num = '0;
      m_val = 1'b0; m_ocu = 1'b0; m_fin = 1'b0;
   endtask

   task automatic tick();
      @(posedge Reloj);
      m_abort = (Reset_n !== 1'b1);
      if (m_abort) m_clear();
   endtask

   task automatic m_run();
      logic r;
      m_est = '0; m_tabla = '0; m_num = '0; m_ocu = 1'b1; m_fin = 1'b0;
      for (int e = 0; e < N; e++) begin
         for (int w = 0; w < 1; w++) begin
            tick();
            if (m_abort) return;
         end
         r = (Respuesta === 1'b1);
         m_tabla[e] = r;
         if (r) begin
            m_num = m_num + 5'd1;
            m_min = 4'(e);
            m_val = 1'b1;
            do begin
               tick();
               if (m_abort) return;
            end while (MintermListo !== 1'b1);
            m_val = 1'b0;
         end
         if (e == N - 1) begin
            m_ocu = 1'b0;
            m_fin = 1'b1;
         end else begin
            m_est = 4'(e + 1);
         end
      end
      tick();
      if (m_abort) return;
      m_fin = 1'b0;
   endtask

   initial begin
      m_clear();
      forever begin
         tick();
         if (!m_abort && Inicio === 1'b1) m_run();
      end
   end

   always @(negedge Reloj) begin
      if (chk_en) begin
         check("model_estimulo", Estimulo,      m_est);
         check("model_tabla",    Tabla,         m_tabla);
         check("model_num",      NumMinterms,   m_num);
         check("model_minterm",  Minterm,       m_min);
         check("model_valido",   MintermValido, m_val);
         check("model_ocupado",  Ocupado,       m_ocu);
         check("model_fin",      Fin,           m_fin);
      end
   end

   // ---------------------------------------------------------------------------
   // stimulus helpers (inputs change 1 ns after the rising edge)
   // ---------------------------------------------------------------------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge Reloj);
         #1;
      end
   endtask

   task automatic snap();
      run_c0  = cycle;
      run_oc0 = ocu_total;
      run_q0  = mq.size();
   endtask

   task automatic begin_run(input bit hold);
      cyc(2);
      Inicio = 1'b1;
      cyc(1);
      if (!hold) Inicio = 1'b0;
      snap();
   endtask

   task automatic wait_fin(output int len);
      len = -1;
      for (int i = 0; i < 300; i++) begin
         if (Fin === 1'b1) begin
            len = cycle - run_c0 + 1;
            return;
         end
         cyc(1);
      end
      check("fin_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_min(input int idx);
      for (int i = 0; i < 100; i++) begin
         if (MintermValido === 1'b1 && Minterm === 4'(idx)) return;
         cyc(1);
      end
      check("minterm_timeout", 32'd0, 32'd1);
   endtask

   task automatic finish_run(input logic [15:0] exp_tabla, input int exp_len, input int exp_mins[$]);
      int len;
      wait_fin(len);
      check("run_length",     len,                  exp_len);
      check("ocupado_cycles", ocu_total - run_oc0,  exp_len - 1);
      check("tabla",          Tabla,                exp_tabla);
      check("num_minterms",   NumMinterms,          exp_mins.size());
      check("handshakes",     mq.size() - run_q0,   exp_mins.size());
      for (int i = 0; i < exp_mins.size() && run_q0 + i < mq.size(); i++)
         check("minterm_order", mq[run_q0 + i], exp_mins[i]);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // directed tests
   // ---------------------------------------------------------------------------
   int mins_sop[$]  = '{3, 7, 11, 12, 13, 14, 15};
   int mins_none[$];
   int mins_all[$];

   initial begin
      int len3;
      Reset_n = 1'b0; Inicio = 1'b0; MintermListo = 1'b1; resp_mode = 0;
      Inicio3 = 1'b0; Listo3 = 1'b1;
      for (int i = 0; i < N; i++) mins_all.push_back(i);

      cyc(2);
      chk_en = 1'b1;
      check("rst_estimulo", Estimulo, 0);
      check("rst_tabla",    Tabla, 0);
      check("rst_num",      NumMinterms, 0);
      check("rst_minterm",  Minterm, 0);
      check("rst_valido",   MintermValido, 0);
      check("rst_ocupado",  Ocupado, 0);
      check("rst_fin",      Fin, 0);
      Reset_n = 1'b1;

      // 1: reference function, consumer always ready
      resp_mode = 0;
      begin_run(1'b0);
      finish_run(16'hF888, 24, mins_sop);

      // 2: tied 0, then tied 1
      resp_mode = 1;
      begin_run(1'b0);
      finish_run(16'h0000, 17, mins_none);
      resp_mode = 2;
      begin_run(1'b0);
      finish_run(16'hFFFF, 33, mins_all);
      check("num_full_range", NumMinterms, 5'b10000);

      // 3: consumer stalls 5 cycles on minterm 7
      resp_mode = 0;
      begin_run(1'b0);
      wait_min(7);
      MintermListo = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc(1);
         check("stall_minterm",  Minterm, 7);
         check("stall_valido",   MintermValido, 1);
         check("stall_estimulo", Estimulo, 7);
      end
      MintermListo = 1'b1;
      finish_run(16'hF888, 29, mins_sop);

      // 4: ESPERA=3 with a 2-cycle-late function, then ESPERA=1 with it
      cyc(2);
      Inicio3 = 1'b1;
      cyc(1);
      Inicio3 = 1'b0;
      run_c0 = cycle;
      len3 = -1;
      for (int i = 0; i < 300; i++) begin
         if (Fin3 === 1'b1) begin
            len3 = cycle - run_c0 + 1;
            break;
         end
         cyc(1);
      end
      check("espera3_length", len3, 56);
      check("espera3_tabla",  Tabla3, 16'hF888);
      check("espera3_num",    Num3, 7);
      resp_mode = 3;
      begin_run(1'b0);
      wait_fin(len3);
      check("espera1_late_table_wrong", Tabla == 16'hF888, 0);

      // 5: reset while offering minterm 11
      resp_mode = 0;
      begin_run(1'b0);
      wait_min(11);
      Reset_n = 1'b0;
      cyc(1);
      Reset_n = 1'b1;
      check("midrst_estimulo", Estimulo, 0);
      check("midrst_tabla",    Tabla, 0);
      check("midrst_num",      NumMinterms, 0);
      check("midrst_minterm",  Minterm, 0);
      check("midrst_valido",   MintermValido, 0);
      check("midrst_ocupado",  Ocupado, 0);
      check("midrst_fin",      Fin, 0);
      cyc(1);
      check("midrst_idle", Ocupado, 0);
      begin_run(1'b0);
      finish_run(16'hF888, 24, mins_sop);

      // 6: Inicio during a sweep is ignored
      begin_run(1'b0);
      cyc(4);
      Inicio = 1'b1;
      cyc(1);
      Inicio = 1'b0;
      finish_run(16'hF888, 24, mins_sop);

      // 6b: Inicio held high gives back-to-back runs
      begin_run(1'b1);
      finish_run(16'hF888, 24, mins_sop);
      cyc(1);
      check("b2b_gap_ocupado", Ocupado, 0);
      check("b2b_gap_tabla",   Tabla, 16'hF888);
      cyc(1);
      check("b2b_restart_ocupado", Ocupado, 1);
      check("b2b_restart_tabla",   Tabla, 0);
      check("b2b_restart_est",     Estimulo, 0);
      snap();
      finish_run(16'hF888, 24, mins_sop);
      Inicio = 1'b0;
      cyc(3);
      check("b2b_stop_idle", Ocupado, 0);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
